// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package pc_sequencer_pkg;

  // RUN: normal next-PC selection. FLUSH: one-cycle bubble after a trap/ERET redirect.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pcseq_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Sequential fetch advance; wraps modulo 2^32.
  function automatic logic [31:0] pc_advance(input logic [31:0] cur);
    return cur + PC_STEP;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Fetch PC register and next-PC source selection (sequential, branch, trap, ERET),
// with a registered one-cycle flush after trap/return redirects and EXL tracking.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] ISR_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        int_req,
  input  logic        int_en,
  input  logic [31:0] exc_pc,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        flush,
  output logic        epc_we,
  output logic [31:0] epc_out,
  output logic        in_handler
);

  pcseq_state_t state;
  logic         trap;

  // Interrupts are masked while already inside a handler; exceptions never are.
  assign trap = exc_req | (int_req & int_en & ~in_handler);

  // Sequencer FSM: all outputs registered, reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      flush      <= 1'b0;
      epc_we     <= 1'b0;
      epc_out    <= 32'd0;
      in_handler <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          flush  <= 1'b0;
          epc_we <= 1'b0;
          if (trap) begin
            // A nested trap keeps the original EPC: no write when already in handler.
            pc         <= ISR_PC;
            state      <= ST_FLUSH;
            flush      <= 1'b1;
            in_handler <= 1'b1;
            epc_we     <= ~in_handler;
            epc_out    <= exc_pc;
          end else if (eret_req) begin
            pc         <= epc;
            state      <= ST_FLUSH;
            flush      <= 1'b1;
            in_handler <= 1'b0;
          end else if (stall) begin
            pc <= pc;
          end else if (br_valid) begin
            pc <= br_target;
          end else begin
            pc <= pc_advance(pc);
          end
        end
        ST_FLUSH: begin
          // Redirect already taken; every request is ignored for this one cycle.
          pc     <= pc_advance(pc);
          state  <= ST_RUN;
          flush  <= 1'b0;
          epc_we <= 1'b0;
        end
        default: begin
          state  <= ST_RUN;
          flush  <= 1'b0;
          epc_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, compared against a behavioural model of the next-PC rules.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] ISR    = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        exc_req = 1'b0;
  logic        int_req = 1'b0;
  logic        int_en = 1'b0;
  logic [31:0] exc_pc = 32'd0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'd0;
  logic [31:0] pc;
  logic        flush;
  logic        epc_we;
  logic [31:0] epc_out;
  logic        in_handler;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the sequencer outputs should be after each edge.
  logic [31:0] m_pc = RST_PC;
  logic        m_flush = 1'b0;
  logic        m_epc_we = 1'b0;
  logic [31:0] m_epc_out = 32'd0;
  logic        m_inh = 1'b0;

  pc_sequencer #(.RESET_PC(RST_PC), .ISR_PC(ISR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_target(br_target), .exc_req(exc_req), .int_req(int_req), .int_en(int_en),
    .exc_pc(exc_pc), .eret_req(eret_req), .epc(epc), .pc(pc), .flush(flush),
    .epc_we(epc_we), .epc_out(epc_out), .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the architectural rules to the inputs seen at this edge.
  task automatic model_edge();
    logic take_trap;
    if (reset) begin
      m_pc = RST_PC; m_flush = 1'b0; m_epc_we = 1'b0; m_epc_out = 32'd0; m_inh = 1'b0;
    end else if (m_flush) begin
      m_pc = m_pc + 32'd4;
      m_flush = 1'b0;
      m_epc_we = 1'b0;
    end else begin
      take_trap = exc_req || (int_req && int_en && !m_inh);
      m_epc_we = 1'b0;
      if (take_trap) begin
        m_epc_we  = !m_inh;
        m_epc_out = exc_pc;
        m_pc      = ISR;
        m_inh     = 1'b1;
        m_flush   = 1'b1;
      end else if (eret_req) begin
        m_pc    = epc;
        m_inh   = 1'b0;
        m_flush = 1'b1;
      end else if (!stall) begin
        m_pc = br_valid ? br_target : m_pc + 32'd4;
      end
    end
  endtask

  // One clock: inputs already set; update model at the edge, compare shortly after.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("pc", pc, m_pc);
    check_eq("flush", {31'd0, flush}, {31'd0, m_flush});
    check_eq("epc_we", {31'd0, epc_we}, {31'd0, m_epc_we});
    check_eq("epc_out", epc_out, m_epc_out);
    check_eq("in_handler", {31'd0, in_handler}, {31'd0, m_inh});
  endtask

  task automatic idle_inputs();
    stall = 0; br_valid = 0; exc_req = 0; eret_req = 0;
  endtask

  initial begin
    // T1: reset two cycles then free-run
    @(negedge clk); reset = 1; step(); step();
    check_eq("t1_rst_pc", pc, 32'h3000);
    check_eq("t1_rst_flush", {31'd0, flush}, 32'd0);
    @(negedge clk); reset = 0; step();
    check_eq("t1_pc1", pc, 32'h3004);
    @(negedge clk); step();
    check_eq("t1_pc2", pc, 32'h3008);

    // T2: stall beats branch, then branch alone
    @(negedge clk); stall = 1; br_valid = 1; br_target = 32'h3100; step();
    check_eq("t2_stall_hold", pc, 32'h3008);
    @(negedge clk); stall = 0; step();
    check_eq("t2_branch", pc, 32'h3100);
    @(negedge clk); idle_inputs(); step();

    // T3: interrupt entry
    @(negedge clk); int_req = 1; int_en = 1; exc_pc = 32'h3010; step();
    check_eq("t3_isr", pc, ISR);
    check_eq("t3_flush", {31'd0, flush}, 32'd1);
    check_eq("t3_epc_we", {31'd0, epc_we}, 32'd1);
    check_eq("t3_epc_out", epc_out, 32'h3010);
    @(negedge clk); step();
    check_eq("t3_isr4", pc, 32'h4184);
    check_eq("t3_flush_end", {31'd0, flush}, 32'd0);

    // T4: interrupt masked in handler; nested exception keeps EPC
    @(negedge clk); step();
    check_eq("t4_masked", pc, 32'h4188);
    @(negedge clk); exc_req = 1; exc_pc = 32'h4188; step();
    check_eq("t4_nested", pc, ISR);
    check_eq("t4_no_epc_we", {31'd0, epc_we}, 32'd0);
    @(negedge clk); exc_req = 0; step();

    // T5: ERET, then level interrupt re-taken after the flush cycle
    @(negedge clk); eret_req = 1; epc = 32'h3014; step();
    check_eq("t5_eret", pc, 32'h3014);
    check_eq("t5_inh_clr", {31'd0, in_handler}, 32'd0);
    @(negedge clk); eret_req = 0; step();
    check_eq("t5_flush_ignore", pc, 32'h3018);
    @(negedge clk); step();
    check_eq("t5_retrap", pc, ISR);

    // T6: trap beats eret; reset aborts flush; PC wrap
    @(negedge clk); int_req = 0; step();
    @(negedge clk); exc_req = 1; eret_req = 1; exc_pc = 32'h5000; step();
    check_eq("t6_trap_wins", pc, ISR);
    @(negedge clk); idle_inputs(); reset = 1; step();
    check_eq("t6_rst_flush", {31'd0, flush}, 32'd0);
    check_eq("t6_rst_pc", pc, 32'h3000);
    @(negedge clk); reset = 0; br_valid = 1; br_target = 32'hFFFF_FFFC; step();
    @(negedge clk); br_valid = 0; step();
    check_eq("t6_wrap", pc, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 99) < 2);
      stall     = ($urandom_range(0, 99) < 20);
      br_valid  = ($urandom_range(0, 99) < 25);
      br_target = {$urandom, 2'b00} ;
      exc_req   = ($urandom_range(0, 99) < 5);
      int_req   = ($urandom_range(0, 99) < 15);
      int_en    = ($urandom_range(0, 99) < 70);
      exc_pc    = {$urandom, 2'b00};
      eret_req  = ($urandom_range(0, 99) < 8);
      epc       = {$urandom, 2'b00};
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
